forwarding_hazard_ctrl: RTL

FORWARDING_HAZARD_CTRL -- requirements
Module: forwarding_hazard_ctrl

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/forward_select.sv | 36 +++
 rtl/forwarding_hazard_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// +--------------------------------------------------------------------+
// | cpu_pkg: shared forwarding encodings and mul/div state type.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

`default_nettype wire

// File: rtl/forward_select.sv
// +--------------------------------------------------------------------+
// | forward_select: picks the ALU operand source for one source reg.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module forward_select
  import cpu_pkg::*;
(
  input  logic [4:0] src_reg_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_reg_write_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_reg_write_i,
  output logic [1:0] sel_o
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = mem_reg_write_i && (mem_rd_i != REG_ZERO) && (mem_rd_i == src_reg_i);
  assign w_wb_hit  = wb_reg_write_i  && (wb_rd_i  != REG_ZERO) && (wb_rd_i  == src_reg_i);

  // The younger EX/MEM value must win over the older MEM/WB one.
  always_comb begin
    sel_o = FWD_IDEX;
    if (w_mem_hit) begin
      sel_o = FWD_EXMEM;
    end else if (w_wb_hit) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/forwarding_hazard_ctrl.sv
// +--------------------------------------------------------------------+
// | forwarding_hazard_ctrl: operand forwarding, load-use and mul/div   |
// | stall control for a 5-stage pipeline.  Rev 1.0                     |
// +--------------------------------------------------------------------+
`default_nettype none

module forwarding_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] idRs_i,
  input  logic [4:0] idRt_i,
  input  logic       idValid_i,
  input  logic [4:0] exRs_i,
  input  logic [4:0] exRt_i,
  input  logic [4:0] exRd_i,
  input  logic       exRegWrite_i,
  input  logic       exMemRead_i,
  input  logic       exMulDiv_i,
  output logic [1:0] forwardA_o,
  output logic [1:0] forwardB_o,
  output logic       pcWrite_o,
  output logic       ifidWrite_o,
  output logic       idexWrite_o,
  output logic       idexFlush_o,
  output logic       busy_o
);

  localparam bit         MD_EN    = (MULDIV_LAT >= 2);
  localparam logic [3:0] CNT_INIT = (MULDIV_LAT >= 2) ? 4'(MULDIV_LAT - 2) : 4'd0;

  md_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
  logic       mem_rw_q, mem_rw_d, wb_rw_q, wb_rw_d;

  logic       md_stall;
  logic       load_use;
  logic [1:0] sel_a, sel_b;

  // The final BUSY cycle (cnt==0) is the one in which the result completes, so it does not stall.
  assign md_stall = ((state_q == MD_IDLE) && exMulDiv_i && MD_EN) ||
                    ((state_q == MD_BUSY) && (cnt_q != 4'd0));

  assign load_use = exMemRead_i && exRegWrite_i && (exRd_i != REG_ZERO) && idValid_i &&
                    ((exRd_i == idRs_i) || (exRd_i == idRt_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= MD_IDLE;
      cnt_q    <= 4'd0;
      mem_rd_q <= REG_ZERO;
      mem_rw_q <= 1'b0;
      wb_rd_q  <= REG_ZERO;
      wb_rw_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_rd_q <= mem_rd_d;
      mem_rw_q <= mem_rw_d;
      wb_rd_q  <= wb_rd_d;
      wb_rw_q  <= wb_rw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (exMulDiv_i && MD_EN) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      MD_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = MD_IDLE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // A stalled EX stage must not appear to advance into MEM.
  always_comb begin
    mem_rd_d = md_stall ? REG_ZERO : exRd_i;
    mem_rw_d = md_stall ? 1'b0     : exRegWrite_i;
    wb_rd_d  = mem_rd_q;
    wb_rw_d  = mem_rw_q;
  end

  forward_select u_fwd_a (
    .src_reg_i       (exRs_i),
    .mem_rd_i        (mem_rd_q),
    .mem_reg_write_i (mem_rw_q),
    .wb_rd_i         (wb_rd_q),
    .wb_reg_write_i  (wb_rw_q),
    .sel_o           (sel_a)
  );

  forward_select u_fwd_b (
    .src_reg_i       (exRt_i),
    .mem_rd_i        (mem_rd_q),
    .mem_reg_write_i (mem_rw_q),
    .wb_rd_i         (wb_rd_q),
    .wb_reg_write_i  (wb_rw_q),
    .sel_o           (sel_b)
  );

  always_comb begin
    forwardA_o  = sel_a;
    forwardB_o  = sel_b;
    pcWrite_o   = 1'b1;
    ifidWrite_o = 1'b1;
    idexWrite_o = 1'b1;
    idexFlush_o = 1'b0;
    busy_o      = 1'b0;
    if (rst_i) begin
      forwardA_o = FWD_IDEX;
      forwardB_o = FWD_IDEX;
    end else if (md_stall) begin
      pcWrite_o   = 1'b0;
      ifidWrite_o = 1'b0;
      idexWrite_o = 1'b0;
      busy_o      = 1'b1;
    end else if (load_use) begin
      pcWrite_o   = 1'b0;
      ifidWrite_o = 1'b0;
      idexFlush_o = 1'b1;
    end
  end

endmodule

`default_nettype wire
